// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the register rename stage.
// Tag widths, architectural/physical register counts and the free-list geometry live here.
package rename_stage_pkg;

   localparam int NUM_PREGS  = 64;
   localparam int PTAG_W     = 6;
   localparam int NUM_AREGS  = 32;
   localparam int AREG_W     = 5;
   localparam int FREE_DEPTH = 32;
   localparam int FREE_PTR_W = 5;
   localparam int FREE_CNT_W = 6;

   typedef logic [PTAG_W-1:0] ptag_t;
   typedef logic [AREG_W-1:0] areg_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic        has_imm;
      logic [1:0]  lw_sw;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } pass_t;

   // x0 is constant, so writes to it never consume a physical register.
   function automatic logic needs_alloc(input logic reg_write, input areg_t dest);
      return reg_write & (dest != 5'd0);
   endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical register tags.
// Reset fills it with the tags that are not mapped by the identity RAT.
module rename_free_list
   import rename_stage_pkg::*;
#(
   parameter int NUM_PREGS = rename_stage_pkg::NUM_PREGS
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  ptag_t                 push_tag,
   input  logic                  pop,
   output ptag_t                 head,
   output logic [FREE_CNT_W-1:0] count
);

   ptag_t                 slots_r [FREE_DEPTH];
   logic [FREE_PTR_W-1:0] head_r;
   logic [FREE_PTR_W-1:0] tail_r;
   logic [FREE_CNT_W-1:0] count_r;
   logic                  push_ok_s;
   logic                  pop_ok_s;

   // Tag 0 is never free, and a push into a full list is dropped.
   always_comb begin
      push_ok_s = push & (push_tag != {PTAG_W{1'b0}}) & (count_r != FREE_CNT_W'(FREE_DEPTH));
      pop_ok_s  = pop & (count_r != {FREE_CNT_W{1'b0}});
   end

   // Pointer, occupancy and storage update.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FREE_DEPTH; i++) begin
            slots_r[i] <= ptag_t'(NUM_PREGS - FREE_DEPTH + i);
         end
         head_r  <= {FREE_PTR_W{1'b0}};
         tail_r  <= {FREE_PTR_W{1'b0}};
         count_r <= FREE_CNT_W'(FREE_DEPTH);
      end else begin
         if (push_ok_s) begin
            slots_r[tail_r] <= push_tag;
            tail_r          <= tail_r + 5'd1;
         end else begin
            tail_r          <= tail_r;
         end
         if (pop_ok_s) begin
            head_r <= head_r + 5'd1;
         end else begin
            head_r <= head_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 6'd1;
            2'b01:   count_r <= count_r - 6'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = slots_r[head_r];
   assign count = count_r;

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: maps architectural sources/destination to physical tags
// through the RAT and the free list, with a one-entry registered output toward dispatch.
module rename_stage
   import rename_stage_pkg::*;
#(
   parameter int NUM_PREGS = rename_stage_pkg::NUM_PREGS
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [6:0]  funct7_in,
   input  logic [31:0] imm_in,
   input  logic        hasImm_in,
   input  logic [1:0]  lwSw_in,
   input  logic        memRead_in,
   input  logic        memWrite_in,
   input  logic        memToReg_in,
   input  logic [4:0]  srcReg1_in,
   input  logic [4:0]  srcReg2_in,
   input  logic [4:0]  destReg_in,
   input  logic        regWrite_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  pSrc1_out,
   output logic [5:0]  pSrc2_out,
   output logic [5:0]  pDest_out,
   output logic [5:0]  oldPDest_out,
   output logic [6:0]  opcode_out,
   output logic [2:0]  funct3_out,
   output logic [6:0]  funct7_out,
   output logic [31:0] imm_out,
   output logic        hasImm_out,
   output logic [1:0]  lwSw_out,
   output logic        memRead_out,
   output logic        memWrite_out,
   output logic        memToReg_out,
   output logic        regWrite_out,
   input  logic        retire_valid,
   input  logic [5:0]  retire_preg,
   output logic [5:0]  free_count
);

   ptag_t                 rat_r [NUM_AREGS];
   logic                  out_valid_r;
   ptag_t                 p_src1_r;
   ptag_t                 p_src2_r;
   ptag_t                 p_dest_r;
   ptag_t                 old_p_dest_r;
   logic                  reg_write_r;
   pass_t                 pass_r;

   pass_t                 pass_in_s;
   ptag_t                 src1_tag_s;
   ptag_t                 src2_tag_s;
   ptag_t                 old_tag_s;
   ptag_t                 head_s;
   logic [FREE_CNT_W-1:0] count_s;
   logic                  needs_alloc_s;
   logic                  in_ready_s;
   logic                  accept_s;
   logic                  alloc_s;

   rename_free_list #(
      .NUM_PREGS (NUM_PREGS)
   ) u_free_list (
      .clk      (clk),
      .rstn     (rstn),
      .push     (retire_valid),
      .push_tag (retire_preg),
      .pop      (alloc_s),
      .head     (head_s),
      .count    (count_s)
   );

   // RAT lookups (pre-update values) and the accept handshake.
   always_comb begin
      pass_in_s.opcode     = opcode_in;
      pass_in_s.funct3     = funct3_in;
      pass_in_s.funct7     = funct7_in;
      pass_in_s.imm        = imm_in;
      pass_in_s.has_imm    = hasImm_in;
      pass_in_s.lw_sw      = lwSw_in;
      pass_in_s.mem_read   = memRead_in;
      pass_in_s.mem_write  = memWrite_in;
      pass_in_s.mem_to_reg = memToReg_in;
      src1_tag_s    = (srcReg1_in == 5'd0) ? {PTAG_W{1'b0}} : rat_r[srcReg1_in];
      src2_tag_s    = (srcReg2_in == 5'd0) ? {PTAG_W{1'b0}} : rat_r[srcReg2_in];
      old_tag_s     = rat_r[destReg_in];
      needs_alloc_s = needs_alloc(regWrite_in, destReg_in);
      // A retire into an empty list only helps from the next cycle on.
      in_ready_s    = rstn & (~out_valid_r | out_ready)
                    & (~needs_alloc_s | (count_s != {FREE_CNT_W{1'b0}}));
      accept_s      = in_valid & in_ready_s;
      alloc_s       = accept_s & needs_alloc_s;
   end

   // RAT: identity map after reset; entry 0 is never written.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_AREGS; i++) begin
            rat_r[i] <= ptag_t'(i);
         end
      end else begin
         if (alloc_s) begin
            rat_r[destReg_in] <= head_s;
         end else begin
            rat_r[destReg_in] <= rat_r[destReg_in];
         end
      end
   end

   // Output register toward dispatch; holds while dispatch stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_r  <= 1'b0;
         p_src1_r     <= {PTAG_W{1'b0}};
         p_src2_r     <= {PTAG_W{1'b0}};
         p_dest_r     <= {PTAG_W{1'b0}};
         old_p_dest_r <= {PTAG_W{1'b0}};
         reg_write_r  <= 1'b0;
         pass_r       <= '{default: '0};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         p_src1_r    <= src1_tag_s;
         p_src2_r    <= src2_tag_s;
         pass_r      <= pass_in_s;
         if (needs_alloc_s) begin
            p_dest_r     <= head_s;
            old_p_dest_r <= old_tag_s;
            reg_write_r  <= 1'b1;
         end else begin
            p_dest_r     <= {PTAG_W{1'b0}};
            old_p_dest_r <= {PTAG_W{1'b0}};
            reg_write_r  <= 1'b0;
         end
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign in_ready     = in_ready_s;
   assign free_count   = count_s;
   assign out_valid    = out_valid_r;
   assign pSrc1_out    = p_src1_r;
   assign pSrc2_out    = p_src2_r;
   assign pDest_out    = p_dest_r;
   assign oldPDest_out = old_p_dest_r;
   assign regWrite_out = reg_write_r;
   assign opcode_out   = pass_r.opcode;
   assign funct3_out   = pass_r.funct3;
   assign funct7_out   = pass_r.funct7;
   assign imm_out      = pass_r.imm;
   assign hasImm_out   = pass_r.has_imm;
   assign lwSw_out     = pass_r.lw_sw;
   assign memRead_out  = pass_r.mem_read;
   assign memWrite_out = pass_r.mem_write;
   assign memToReg_out = pass_r.mem_to_reg;

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: a RAT/free-list model predicts each renamed output.
`timescale 1ns/1ps
module tb_rename_stage;

   logic        clk = 1'b0;
   logic        rstn, in_valid, in_ready, out_valid, out_ready;
   logic [6:0]  opcode_in, funct7_in, opcode_out, funct7_out;
   logic [2:0]  funct3_in, funct3_out;
   logic [31:0] imm_in, imm_out;
   logic        hasImm_in, memRead_in, memWrite_in, memToReg_in, regWrite_in;
   logic        hasImm_out, memRead_out, memWrite_out, memToReg_out, regWrite_out;
   logic [1:0]  lwSw_in, lwSw_out;
   logic [4:0]  srcReg1_in, srcReg2_in, destReg_in;
   logic [5:0]  pSrc1_out, pSrc2_out, pDest_out, oldPDest_out;
   logic        retire_valid;
   logic [5:0]  retire_preg, free_count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [5:0] p1, p2, pd, old;
      logic rw;
      logic [6:0] opcode; logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
      logic has_imm; logic [1:0] lw_sw; logic mr, mw, m2r;
   } out_t;

   typedef struct packed {
      logic [4:0] s1, s2, d;
      logic rw;
      logic [6:0] opcode; logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
      logic has_imm; logic [1:0] lw_sw; logic mr, mw, m2r;
   } instr_t;

   out_t exp_q [$];
   int   rat_m [32];
   int   fl_m  [$];

   always #5 clk = ~clk;

   rename_stage dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in), .imm_in(imm_in),
      .hasImm_in(hasImm_in), .lwSw_in(lwSw_in), .memRead_in(memRead_in),
      .memWrite_in(memWrite_in), .memToReg_in(memToReg_in),
      .srcReg1_in(srcReg1_in), .srcReg2_in(srcReg2_in), .destReg_in(destReg_in),
      .regWrite_in(regWrite_in), .out_valid(out_valid), .out_ready(out_ready),
      .pSrc1_out(pSrc1_out), .pSrc2_out(pSrc2_out), .pDest_out(pDest_out),
      .oldPDest_out(oldPDest_out), .opcode_out(opcode_out), .funct3_out(funct3_out),
      .funct7_out(funct7_out), .imm_out(imm_out), .hasImm_out(hasImm_out),
      .lwSw_out(lwSw_out), .memRead_out(memRead_out), .memWrite_out(memWrite_out),
      .memToReg_out(memToReg_out), .regWrite_out(regWrite_out),
      .retire_valid(retire_valid), .retire_preg(retire_preg), .free_count(free_count)
   );

   function automatic instr_t mk(input int s1, input int s2, input int d, input bit rw, input bit mw);
      instr_t t;
      t.s1 = 5'(s1); t.s2 = 5'(s2); t.d = 5'(d); t.rw = rw; t.mw = mw;
      t.opcode = 7'($urandom); t.f3 = 3'($urandom); t.f7 = 7'($urandom);
      t.imm = $urandom; t.has_imm = 1'($urandom_range(0, 1));
      t.lw_sw = 2'($urandom_range(0, 3)); t.mr = 1'($urandom_range(0, 1));
      t.m2r = 1'($urandom_range(0, 1));
      return t;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) rat_m[i] = i;
      fl_m.delete();
      for (int i = 32; i < 64; i++) fl_m.push_back(i);
   endfunction

   function automatic void model_retire(input int tag);
      if (tag != 0 && fl_m.size() < 32) fl_m.push_back(tag);
   endfunction

   function automatic void model_accept(input instr_t t);
      out_t e;
      e.p1 = (t.s1 == 5'd0) ? 6'd0 : 6'(rat_m[t.s1]);
      e.p2 = (t.s2 == 5'd0) ? 6'd0 : 6'(rat_m[t.s2]);
      if (t.rw && t.d != 5'd0 && fl_m.size() > 0) begin
         e.pd = 6'(fl_m.pop_front());
         e.old = 6'(rat_m[t.d]);
         rat_m[t.d] = int'(e.pd);
         e.rw = 1'b1;
      end else begin
         e.pd = 6'd0; e.old = 6'd0; e.rw = 1'b0;
      end
      e.opcode = t.opcode; e.f3 = t.f3; e.f7 = t.f7; e.imm = t.imm;
      e.has_imm = t.has_imm; e.lw_sw = t.lw_sw; e.mr = t.mr; e.mw = t.mw; e.m2r = t.m2r;
      exp_q.push_back(e);
   endfunction

   task automatic drive_fields(input instr_t t);
      opcode_in = t.opcode; funct3_in = t.f3; funct7_in = t.f7; imm_in = t.imm;
      hasImm_in = t.has_imm; lwSw_in = t.lw_sw; memRead_in = t.mr; memWrite_in = t.mw;
      memToReg_in = t.m2r; srcReg1_in = t.s1; srcReg2_in = t.s2; destReg_in = t.d;
      regWrite_in = t.rw;
   endtask

   // Present one instruction (optionally with a same-cycle retire) until accepted.
   task automatic send(input instr_t t, input int rtag, input int budget);
      bit done = 1'b0;
      @(negedge clk);
      drive_fields(t);
      in_valid = 1'b1;
      retire_valid = (rtag >= 0);
      retire_preg = (rtag >= 0) ? 6'(rtag) : 6'd0;
      for (int n = 0; n < budget && !done; n++) begin
         #1;
         if (in_ready === 1'b1) begin
            model_accept(t);
            if (rtag >= 0) model_retire(rtag);
            @(posedge clk);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL accept_timeout: in_ready got 0, required 1 within %0d cycles", budget);
      end
      #1;
      in_valid = 1'b0;
      retire_valid = 1'b0;
   endtask

   task automatic retire(input int tag);
      @(negedge clk);
      retire_valid = 1'b1; retire_preg = 6'(tag);
      @(posedge clk);
      model_retire(tag);
      #1 retire_valid = 1'b0;
   endtask

   task automatic apply_reset(input bit check);
      @(negedge clk);
      rstn = 1'b0; in_valid = 1'b0; retire_valid = 1'b0;
      #1;
      if (check) begin
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
         total++; if (free_count !== 6'd32) begin bad++; $display("FAIL rst_free_count: got %0d required 32", free_count); end
         total++; if (pDest_out !== 6'd0) begin bad++; $display("FAIL rst_pdest: got %0d required 0", pDest_out); end
      end
      model_reset();
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Scoreboard: every handshake at dispatch pops one predicted result.
   always begin : monitor
      out_t a, e;
      @(negedge clk);
      #2;
      if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         a = {pSrc1_out, pSrc2_out, pDest_out, oldPDest_out, regWrite_out, opcode_out, funct3_out,
              funct7_out, imm_out, hasImm_out, lwSw_out, memRead_out, memWrite_out, memToReg_out};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got pDest=%0d, required no output", pDest_out);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               bad++;
               $display("FAIL renamed_out: got %h required %h", a, e);
            end
         end
      end
   end

   task automatic test_reset();
      apply_reset(1'b1);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b required 1", in_ready); end
      total++; if (free_count !== 6'd32) begin bad++; $display("FAIL post_rst_count: got %0d required 32", free_count); end
   endtask

   task automatic test_basic();
      apply_reset(1'b0);
      send(mk(1, 2, 3, 1'b1, 1'b0), -1, 4);
      @(negedge clk); #1;
      total++; if (pSrc1_out !== 6'd1) begin bad++; $display("FAIL basic_psrc1: got %0d required 1", pSrc1_out); end
      total++; if (pSrc2_out !== 6'd2) begin bad++; $display("FAIL basic_psrc2: got %0d required 2", pSrc2_out); end
      total++; if (pDest_out !== 6'd32) begin bad++; $display("FAIL basic_pdest: got %0d required 32", pDest_out); end
      total++; if (oldPDest_out !== 6'd3) begin bad++; $display("FAIL basic_old: got %0d required 3", oldPDest_out); end
      total++; if (free_count !== 6'd31) begin bad++; $display("FAIL basic_count: got %0d required 31", free_count); end
   endtask

   task automatic test_back_to_back();
      apply_reset(1'b0);
      send(mk(1, 0, 5, 1'b1, 1'b0), -1, 4);
      send(mk(5, 0, 6, 1'b1, 1'b0), -1, 4);
      @(negedge clk); #1;
      total++; if (pSrc1_out !== 6'd32) begin bad++; $display("FAIL dep_psrc1: got %0d required 32", pSrc1_out); end
      total++; if (pDest_out !== 6'd33) begin bad++; $display("FAIL dep_pdest: got %0d required 33", pDest_out); end
   endtask

   task automatic test_no_alloc();
      apply_reset(1'b0);
      send(mk(1, 2, 7, 1'b0, 1'b1), -1, 4);
      send(mk(3, 4, 0, 1'b1, 1'b0), -1, 4);
      send(mk(5, 6, 9, 1'b0, 1'b0), -1, 4);
      @(negedge clk); #1;
      total++; if (pDest_out !== 6'd0) begin bad++; $display("FAIL noalloc_pdest: got %0d required 0", pDest_out); end
      total++; if (regWrite_out !== 1'b0) begin bad++; $display("FAIL noalloc_rw: got %b required 0", regWrite_out); end
      total++; if (free_count !== 6'd32) begin bad++; $display("FAIL noalloc_count: got %0d required 32", free_count); end
      send(mk(7, 9, 0, 1'b0, 1'b0), -1, 4);
   endtask

   task automatic test_stall();
      instr_t b;
      apply_reset(1'b0);
      out_ready = 1'b0;
      send(mk(1, 2, 3, 1'b1, 1'b0), -1, 4);
      b = mk(4, 5, 6, 1'b1, 1'b0);
      @(negedge clk);
      drive_fields(b);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c%0d: got %b required 0", k, in_ready); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d: got %b required 1", k, out_valid); end
         total++; if (pDest_out !== 6'd32) begin bad++; $display("FAIL stall_pdest c%0d: got %0d required 32", k, pDest_out); end
         total++; if (oldPDest_out !== 6'd3) begin bad++; $display("FAIL stall_old c%0d: got %0d required 3", k, oldPDest_out); end
         total++; if (free_count !== 6'd31) begin bad++; $display("FAIL stall_count c%0d: got %0d required 31", k, free_count); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      send(b, -1, 4);
      @(negedge clk); #1;
      total++; if (free_count !== 6'd30) begin bad++; $display("FAIL stall_after_count: got %0d required 30", free_count); end
   endtask

   task automatic test_exhaust();
      instr_t t;
      apply_reset(1'b0);
      for (int i = 0; i < 32; i++) send(mk(i % 31 + 1, (i + 3) % 32, i % 31 + 1, 1'b1, 1'b0), -1, 4);
      @(negedge clk); #1;
      total++; if (free_count !== 6'd0) begin bad++; $display("FAIL exh_count: got %0d required 0", free_count); end
      t = mk(2, 3, 4, 1'b1, 1'b0);
      drive_fields(t);
      in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL exh_ready: got %b required 0", in_ready); end
      @(negedge clk);
      retire_valid = 1'b1; retire_preg = 6'd7;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL exh_no_bypass: got %b required 0", in_ready); end
      @(posedge clk);
      model_retire(7);
      #1 retire_valid = 1'b0; in_valid = 1'b0;
      @(negedge clk); #1;
      total++; if (free_count !== 6'd1) begin bad++; $display("FAIL exh_retired_count: got %0d required 1", free_count); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL exh_ready_again: got %b required 1", in_ready); end
      send(t, -1, 4);
      @(negedge clk); #1;
      total++; if (pDest_out !== 6'd7) begin bad++; $display("FAIL exh_pdest: got %0d required 7", pDest_out); end
   endtask

   task automatic test_retire();
      apply_reset(1'b0);
      retire(40);
      @(negedge clk); #1;
      total++; if (free_count !== 6'd32) begin bad++; $display("FAIL full_drop_count: got %0d required 32", free_count); end
      send(mk(1, 2, 3, 1'b1, 1'b0), -1, 4);
      retire(0);
      @(negedge clk); #1;
      total++; if (free_count !== 6'd31) begin bad++; $display("FAIL zero_retire_count: got %0d required 31", free_count); end
      send(mk(4, 5, 6, 1'b1, 1'b0), 50, 4);
      @(negedge clk); #1;
      total++; if (free_count !== 6'd31) begin bad++; $display("FAIL push_pop_count: got %0d required 31", free_count); end
      for (int i = 0; i < 31; i++) send(mk(i + 1, 31 - i, (i % 30) + 2, 1'b1, 1'b0), -1, 4);
      @(negedge clk); #1;
      total++; if (pDest_out !== 6'd50) begin bad++; $display("FAIL wrap_pdest: got %0d required 50", pDest_out); end
   endtask

   task automatic test_reset_mid_stall();
      apply_reset(1'b0);
      out_ready = 1'b0;
      send(mk(1, 2, 3, 1'b1, 1'b0), -1, 4);
      @(negedge clk);
      #3 rstn = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
      total++; if (free_count !== 6'd32) begin bad++; $display("FAIL midrst_count: got %0d required 32", free_count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b required 0", in_ready); end
      model_reset();
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1; out_ready = 1'b1;
      #1;
      total++; if (free_count !== 6'd32) begin bad++; $display("FAIL midrst_rel_count: got %0d required 32", free_count); end
      for (int i = 1; i < 32; i += 2) send(mk(i, (i + 1) % 32, 0, 1'b0, 1'b0), -1, 4);
      send(mk(3, 0, 3, 1'b1, 1'b0), -1, 4);
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; retire_valid = 1'b0; retire_preg = 6'd0;
      drive_fields(mk(0, 0, 0, 1'b0, 1'b0));
      model_reset();
      test_reset();
      test_basic();
      test_back_to_back();
      test_no_alloc();
      test_stall();
      test_exhaust();
      test_retire();
      test_reset_mid_stall();
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending outputs, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
